uart_tx_serializer: RTL and testbench

- UART transmit engine directly downstream of the UART register block.
- Consumes tx_data, frame config (data bits, stop bits, parity) and the start_tx request; drives the serial tx line.
- Returns start_tx_down (request-accept pulse that clears the start_tx control bit) and tx_done (status bit read back through the status register).
- Contains its own baud divider, frame FSM and shadow registers.

---
 rtl/uart_tx_serializer.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: baud divider, frame FSM and shadow config registers.
// Optional macro UART_TX_BREAK_EN adds a send_break input that holds the line low while idle.
module uart_tx_serializer #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       start_tx,
`ifdef UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       start_tx_down,
    output logic       tx_done,
    output logic       tx
);

    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      state_r,     state_s;
    logic [15:0] baud_cnt_r,  baud_cnt_s;
    logic [2:0]  bit_cnt_r,   bit_cnt_s;
    logic [7:0]  data_r,      data_s;
    logic [1:0]  dbits_r,     dbits_s;
    logic        sbits_r,     sbits_s;
    logic        pen_r,       pen_s;
    logic        ptype_r,     ptype_s;
    logic        tx_r,        tx_s;
    logic        down_r,      down_s;
    logic        done_r,      done_s;
    logic        baud_end_s;
    logic        accept_s;
    logic [2:0]  last_data_s;

    // Parity over only the bits actually sent; upper bits are masked off.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                        input logic odd);
        logic [7:0] mask;
        case (dbits)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            2'b11:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return (^(data & mask)) ^ odd;
    endfunction

    assign tx            = tx_r;
    assign start_tx_down = down_r;
    assign tx_done       = done_r;

    // Next-state, baud/bit counters, shadow latch and registered outputs.
    always_comb begin
        state_s     = state_r;
        baud_cnt_s  = baud_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        data_s      = data_r;
        dbits_s     = dbits_r;
        sbits_s     = sbits_r;
        pen_s       = pen_r;
        ptype_s     = ptype_r;
        tx_s        = tx_r;
        down_s      = 1'b0;
        done_s      = done_r;
        baud_end_s  = (baud_cnt_r == BAUD_MAX);
        last_data_s = 3'd4 + {1'b0, dbits_r};
`ifdef UART_TX_BREAK_EN
        // A break leaves tx_r low, so a request waits one edge after release.
        accept_s    = start_tx && !send_break && tx_r;
`else
        accept_s    = start_tx;
`endif

        if (state_r != ST_IDLE) begin
            if (baud_end_s) begin
                baud_cnt_s = 16'd0;
            end else begin
                baud_cnt_s = baud_cnt_r + 16'd1;
            end
        end else begin
            baud_cnt_s = 16'd0;
        end

        case (state_r)
            ST_IDLE: begin
                bit_cnt_s = 3'd0;
`ifdef UART_TX_BREAK_EN
                tx_s = !send_break;
`else
                tx_s = 1'b1;
`endif
                if (accept_s) begin
                    data_s  = tx_data;
                    dbits_s = data_bit_num;
                    sbits_s = stop_bit_num;
                    pen_s   = parity_en;
                    ptype_s = parity_type;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                    down_s  = 1'b1;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = data_r[0];
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    if (bit_cnt_r == last_data_s) begin
                        bit_cnt_s = 3'd0;
                        if (pen_r) begin
                            state_s = ST_PARITY;
                            tx_s    = parity_bit(data_r, dbits_r, ptype_r);
                        end else begin
                            state_s = ST_STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = data_r[bit_cnt_r + 3'd1];
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_s   = ST_STOP;
                    bit_cnt_s = 3'd0;
                    tx_s      = 1'b1;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (baud_end_s) begin
                    if (bit_cnt_r == {2'b00, sbits_r}) begin
                        state_s   = ST_IDLE;
                        bit_cnt_s = 3'd0;
                        done_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tx_s       = 1'b1;
                baud_cnt_s = 16'd0;
                bit_cnt_s  = 3'd0;
            end
        endcase
    end

    // State and output registers with asynchronous abort to an idle-high line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            data_r     <= 8'd0;
            dbits_r    <= 2'd0;
            sbits_r    <= 1'b0;
            pen_r      <= 1'b0;
            ptype_r    <= 1'b0;
            tx_r       <= 1'b1;
            down_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            data_r     <= data_s;
            dbits_r    <= dbits_s;
            sbits_r    <= sbits_s;
            pen_r      <= pen_s;
            ptype_r    <= ptype_s;
            tx_r       <= tx_s;
            down_r     <= down_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table vectors, corner sequences and
// randomized frames against a bit-list frame model.
module tb_uart_tx_serializer;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic [1:0] data_bit_num = 2'd0;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       start_tx = 1'b0;
    logic       start_tx_down;
    logic       tx_done;
    logic       tx;
`ifdef UART_TX_BREAK_EN
    logic       send_break = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic        sbits;
        logic        pen;
        logic        ptype;
        logic [11:0] seq;
        int          n;
    } vec_t;

    vec_t tbl [4];

    uart_tx_serializer #(.CLK_DIV(CD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .start_tx     (start_tx),
`ifdef UART_TX_BREAK_EN
        .send_break   (send_break),
`endif
        .start_tx_down(start_tx_down),
        .tx_done      (tx_done),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as a list of line levels, one per bit time, first bit in index 0.
    function automatic int model(input logic [7:0] d, input logic [1:0] db, input logic sb,
                                 input logic pen, input logic pt, output logic [11:0] seq);
        int nd;
        int k;
        logic [7:0] m;
        nd  = 5 + int'(db);
        seq = '0;
        k   = 1;
        for (int i = 0; i < nd; i++) begin
            seq[k] = d[i];
            k++;
        end
        if (pen) begin
            m = d & 8'((1 << nd) - 1);
            seq[k] = (($countones(m) % 2) == 1) ^ pt;
            k++;
        end
        for (int i = 0; i < 1 + int'(sb); i++) begin
            seq[k] = 1'b1;
            k++;
        end
        return k;
    endfunction

    function automatic logic [63:0] expand(input logic [11:0] seq, input int n);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < CD; j++)
                w[i*CD + j] = seq[i];
        return w;
    endfunction

    task automatic drive_cfg(input logic [7:0] d, input logic [1:0] db, input logic sb,
                             input logic pen, input logic pt);
        tx_data      = d;
        data_bit_num = db;
        stop_bit_num = sb;
        parity_en    = pen;
        parity_type  = pt;
    endtask

    // Accept one request, then record tx every cycle until tx_done rises.
    task automatic do_frame(input logic [63:0] exp_wave, input int exp_len, input bit change,
                            input bit hold, input string tag);
        logic [63:0] wave;
        int len;
        start_tx = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".down"}, 64'(start_tx_down), 64'd1);
        chk({tag, ".done_clr"}, 64'(tx_done), 64'd0);
        if (!hold) start_tx = 1'b0;
        wave = '0;
        len  = 0;
        while (tx_done !== 1'b1 && len < 64) begin
            wave[len] = tx;
            if (len == 1) begin
                chk({tag, ".pulse1"}, 64'(start_tx_down), 64'd0);
                if (change) drive_cfg(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
            end
            len++;
            @(posedge clk); #1;
        end
        chk({tag, ".len"}, 64'(len), 64'(exp_len));
        chk({tag, ".wave"}, wave, exp_wave);
        chk({tag, ".idle_tx"}, 64'(tx), 64'd1);
    endtask

    initial begin
        logic [11:0] seq;
        int n;
        logic [7:0] d;
        logic [1:0] db;
        logic sb, pen, pt;

        tbl[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'b00_1101001010, 10};
        tbl[1] = '{8'h55, 2'b10, 1'b1, 1'b1, 1'b0, 12'b0_11010101010, 11};
        tbl[2] = '{8'h1F, 2'b00, 1'b0, 1'b1, 1'b1, 12'b0000_10111110, 8};
        tbl[3] = '{8'h1E, 2'b00, 1'b0, 1'b1, 1'b1, 12'b0000_11111100, 8};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.tx", 64'(tx), 64'd1);
        chk("rst.down", 64'(start_tx_down), 64'd0);
        chk("rst.done", 64'(tx_done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            drive_cfg(tbl[i].data, tbl[i].dbits, tbl[i].sbits, tbl[i].pen, tbl[i].ptype);
            do_frame(expand(tbl[i].seq, tbl[i].n), tbl[i].n * CD, 1'b0, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.done_hold", i), 64'(tx_done), 64'd1);
        end

        // Inputs change one cycle after the accept pulse: frame keeps latched 8N1 0xFF.
        drive_cfg(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0);
        n = model(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, seq);
        do_frame(expand(seq, n), n * CD, 1'b1, 1'b0, "latch");
        n = model(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, seq);
        do_frame(expand(seq, n), n * CD, 1'b0, 1'b0, "latch_next");

        // start_tx held across two frames: one idle-high cycle between them.
        drive_cfg(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
        n = model(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, seq);
        do_frame(expand(seq, n), n * CD, 1'b0, 1'b1, "b2b_a");
        chk("b2b.gap_done", 64'(tx_done), 64'd1);
        chk("b2b.gap_down", 64'(start_tx_down), 64'd0);
        do_frame(expand(seq, n), n * CD, 1'b0, 1'b0, "b2b_b");

        // Reset mid-DATA aborts immediately.
        drive_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
        start_tx = 1'b1;
        @(posedge clk); #1;
        start_tx = 1'b0;
        chk("rmid.down", 64'(start_tx_down), 64'd1);
        repeat (2 * CD) @(posedge clk);
        #1;
        chk("rmid.pre_tx", 64'(tx), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid.tx", 64'(tx), 64'd1);
        chk("rmid.done", 64'(tx_done), 64'd0);
        chk("rmid.down0", 64'(start_tx_down), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_cfg(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0);
        n = model(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, seq);
        do_frame(expand(seq, n), n * CD, 1'b0, 1'b0, "post_rst");

`ifdef UART_TX_BREAK_EN
        // Break in idle holds tx low and blocks the request until released.
        send_break = 1'b1;
        start_tx   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("brk.tx", 64'(tx), 64'd0);
            chk("brk.down", 64'(start_tx_down), 64'd0);
        end
        send_break = 1'b0;
        @(posedge clk); #1;
        chk("brk.rel_tx", 64'(tx), 64'd1);
        chk("brk.rel_down", 64'(start_tx_down), 64'd0);
        do_frame(expand(seq, n), n * CD, 1'b0, 1'b0, "brk_frame");
`endif

        for (int r = 0; r < 25; r++) begin
            d   = 8'($urandom);
            db  = 2'($urandom_range(0, 3));
            sb  = 1'($urandom_range(0, 1));
            pen = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            drive_cfg(d, db, sb, pen, pt);
            n = model(d, db, sb, pen, pt, seq);
            do_frame(expand(seq, n), n * CD, 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
